// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined accumulator ALU with valid/ready handshakes.
//
// Stage S1 registers an accepted request (opcode, accumulator, data operand).
// Stage S2 registers the computed result together with its zero/carry flags
// and the opcode that produced it. Both stages advance independently, so a
// stage may accept and drain on the same edge. The pipeline sustains one
// operation per cycle while out_ready is high.
//
// Optional feature (compile-time macro):
//   ALU_PIPE_SAT_EN  when defined, ADD saturates to all-ones on carry-out
//                    (out_carry still 1) and out_zero follows the saturated
//                    value. When undefined, ADD wraps modulo 2^WIDTH.
//
// Parameters:
//   WIDTH        operand/result width in bits (2..64), default 8
//
// Ports:
//   clk          clock, rising-edge active
//   rst_         asynchronous active-low reset
//   in_valid     request valid
//   in_ready     request can be accepted this cycle
//   in_opcode    operation (alu_pipe_pkg::opcode_t encoding)
//   in_accum     accumulator operand
//   in_data      data operand
//   out_valid    result valid
//   out_ready    downstream consumes the result this cycle
//   out_result   operation result
//   out_zero     out_result == 0
//   out_carry    unsigned carry out of ADD, 0 for every other opcode
//   out_opcode   opcode that produced out_result
// -----------------------------------------------------------------------------

package alu_pipe_pkg;
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;
endpackage

module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [WIDTH-1:0] in_accum,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic [2:0]       out_opcode
);

    // ------------------------------------------------------------------
    // Stage S1: captured request
    // ------------------------------------------------------------------
    logic             s1_valid;
    opcode_t          s1_opcode;
    logic [WIDTH-1:0] s1_accum;
    logic [WIDTH-1:0] s1_data;

    // S2 can take a new value when it is empty or is being drained now.
    logic s2_take;
    assign s2_take = !out_valid || out_ready;

    // Reset is folded in so the block advertises "not ready" while held in
    // reset; otherwise this depends only on registered state and out_ready.
    assign in_ready = rst_ && (!s1_valid || s2_take);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            s1_valid  <= 1'b0;
            s1_opcode <= HLT;
            // NOTE: payload registers are reset as well so that nothing
            // undefined can ever reach the outputs; they are few bits wide.
            s1_accum  <= '0;
            s1_data   <= '0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid  <= 1'b1;
                s1_opcode <= opcode_t'(in_opcode);
                s1_accum  <= in_accum;
                s1_data   <= in_data;
            end else if (s2_take) begin
                // Current occupant (if any) moves into S2 this edge.
                s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // ALU between S1 and S2
    // ------------------------------------------------------------------
    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        alu_sum    = {1'b0, s1_data} + {1'b0, s1_accum};
        alu_result = s1_accum;
        alu_carry  = 1'b0;
        case (s1_opcode)
            ADD: begin
                alu_result = alu_sum[WIDTH-1:0];
                alu_carry  = alu_sum[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                if (alu_sum[WIDTH]) begin
                    alu_result = '1;
                end
`endif
            end
            AND:     alu_result = s1_data & s1_accum;
            XOR:     alu_result = s1_data ^ s1_accum;
            LDA:     alu_result = s1_data;
            // HLT, SKZ, STO, JMP and any unknown encoding pass the accumulator.
            default: alu_result = s1_accum;
        endcase
        alu_zero = (alu_result == '0);
    end

    // ------------------------------------------------------------------
    // Stage S2: registered result and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_carry  <= 1'b0;
            out_opcode <= HLT;
        end else if (s2_take) begin
            out_valid <= s1_valid;
            // Flags are loaded together with the result, so they always
            // describe the operation currently presented.
            if (s1_valid) begin
                out_result <= alu_result;
                out_zero   <= alu_zero;
                out_carry  <= alu_carry;
                out_opcode <= s1_opcode;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int W = 8;

    // ------------------------------------------------------------------
    // DUT (WIDTH=8) signals
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst_ = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_opcode = 3'd0;
    logic [W-1:0] in_accum = '0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_carry;
    logic [2:0]   out_opcode;

    // Second instance at WIDTH=16 for the wide-carry case
    logic         w_in_valid = 1'b0;
    logic         w_in_ready;
    logic [2:0]   w_in_opcode = 3'd0;
    logic [15:0]  w_in_accum = '0;
    logic [15:0]  w_in_data = '0;
    logic         w_out_valid;
    logic         w_out_ready = 1'b1;
    logic [15:0]  w_out_result;
    logic         w_out_zero;
    logic         w_out_carry;
    logic [2:0]   w_out_opcode;

    alu_pipe #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst_       (rst_),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_accum   (in_accum),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_opcode (out_opcode)
    );

    alu_pipe #(.WIDTH(16)) u_dut16 (
        .clk        (clk),
        .rst_       (rst_),
        .in_valid   (w_in_valid),
        .in_ready   (w_in_ready),
        .in_opcode  (w_in_opcode),
        .in_accum   (w_in_accum),
        .in_data    (w_in_data),
        .out_valid  (w_out_valid),
        .out_ready  (w_out_ready),
        .out_result (w_out_result),
        .out_zero   (w_out_zero),
        .out_carry  (w_out_carry),
        .out_opcode (w_out_opcode)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] result;
        logic         zero;
        logic         carry;
        logic [2:0]   opcode;
        int           acc_cyc;
        int           out_cyc;
    } item_t;

    item_t sb_q[$];
    item_t got_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: operation semantics written with plain integer math.
    function automatic item_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] d);
        item_t        it;
        longint       s;
        longint       modulus;
        modulus   = longint'(1) << W;
        it.carry  = 1'b0;
        it.opcode = op;
        it.acc_cyc = 0;
        it.out_cyc = 0;
        case (op)
            3'(ADD): begin
                s = longint'(a) + longint'(d);
                it.carry  = (s >= modulus);
`ifdef ALU_PIPE_SAT_EN
                it.result = it.carry ? {W{1'b1}} : W'(s);
`else
                it.result = W'(s % modulus);
`endif
            end
            3'(AND): it.result = a & d;
            3'(XOR): it.result = a ^ d;
            3'(LDA): it.result = d;
            default: it.result = a;
        endcase
        it.zero = (it.result == '0);
        return it;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: pushes expectations on accept, pops and compares on output
    // transfer, and checks output stability under backpressure.
    // ------------------------------------------------------------------
    logic         prev_stall = 1'b0;
    logic [12:0]  prev_out = '0;
    item_t        mon_e;

    always @(negedge clk) begin
        if (!rst_) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold_stable", {out_opcode, out_carry, out_zero, out_result}, prev_out);
            if (in_valid && in_ready) begin
                mon_e = model(in_opcode, in_accum, in_data);
                mon_e.acc_cyc = cyc;
                sb_q.push_back(mon_e);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("scoreboard", {out_opcode, out_carry, out_zero, out_result},
                          {mon_e.opcode, mon_e.carry, mon_e.zero, mon_e.result});
                    mon_e.out_cyc = cyc;
                    got_q.push_back(mon_e);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_opcode, out_carry, out_zero, out_result};
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1ns after the rising edge)
    // ------------------------------------------------------------------
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] d);
        in_valid  = 1'b1;
        in_opcode = op;
        in_accum  = a;
        in_data   = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("issue_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

`ifdef ALU_PIPE_SAT_EN
    localparam logic [7:0]  EXP_ADD8   = 8'hFF;
    localparam logic [15:0] EXP_ADD16  = 16'hFFFF;
    localparam logic        EXP_ZERO16 = 1'b0;
`else
    localparam logic [7:0]  EXP_ADD8   = 8'h10;
    localparam logic [15:0] EXP_ADD16  = 16'h0000;
    localparam logic        EXP_ZERO16 = 1'b1;
`endif

    int acc_cnt;
    int vis_cnt;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_outputs", {out_opcode, out_carry, out_zero, out_result}, {3'(HLT), 1'b0, 1'b0, 8'h00});
        rst_ = 1'b1;
        #1;
        check("in_ready_after_release", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // ---------------- ADD with carry ----------------
        got_q.delete();
        issue(3'(ADD), 8'hF0, 8'h20);
        drain();
        check("add_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) begin
            check("add_result", 64'(got_q[0].result), 64'(EXP_ADD8));
            check("add_carry", 64'(got_q[0].carry), 64'd1);
            check("add_zero", 64'(got_q[0].zero), 64'd0);
            // Result registered in S2 after edge N+1, handed over on edge N+2.
            check("add_latency", 64'(got_q[0].out_cyc - got_q[0].acc_cyc), 64'd2);
        end

        // ---------------- back-to-back XOR / LDA / AND ----------------
        got_q.delete();
        issue(3'(XOR), 8'hAA, 8'hAA);
        issue(3'(LDA), 8'h77, 8'h5C);
        issue(3'(AND), 8'h0F, 8'hF3);
        drain();
        check("b2b_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() >= 3) begin
            check("b2b_xor", {got_q[0].zero, got_q[0].result}, {1'b1, 8'h00});
            check("b2b_lda", {got_q[1].zero, got_q[1].result}, {1'b0, 8'h5C});
            check("b2b_and", {got_q[2].zero, got_q[2].result}, {1'b0, 8'h03});
            check("b2b_consecutive1", 64'(got_q[1].out_cyc - got_q[0].out_cyc), 64'd1);
            check("b2b_consecutive2", 64'(got_q[2].out_cyc - got_q[1].out_cyc), 64'd1);
        end

        // ---------------- backpressure: 5 cycles out_ready=0 ----------------
        got_q.delete();
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_opcode = 3'($urandom_range(0, 7));
            in_accum  = 8'($urandom);
            in_data   = 8'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_accepts", 64'(acc_cnt), 64'd2);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        drain();
        check("bp_delivered", 64'(got_q.size()), 64'd2);

        // ---------------- random traffic, 1000 operations ----------------
        acc_cnt = 0;
        for (int c = 0; c < 20000 && acc_cnt < 1000; c++) begin
            in_valid  = 1'($urandom);
            in_opcode = 3'($urandom);
            in_accum  = 8'($urandom);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("random_accepted", 64'(acc_cnt), 64'd1000);
        drain();

        // ---------------- reset with both stages full ----------------
        out_ready = 1'b0;
        issue(3'(ADD), 8'h11, 8'h22);
        issue(3'(XOR), 8'h33, 8'h0F);
        in_valid = 1'b0;
        @(negedge clk);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        #1;
        rst_ = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        out_ready = 1'b1;
        vis_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) vis_cnt++;
        end
        check("no_stale_after_reset", 64'(vis_cnt), 64'd0);

        // ---------------- WIDTH=16 ADD wrap ----------------
        @(posedge clk);
        #1;
        w_in_valid  = 1'b1;
        w_in_opcode = 3'(ADD);
        w_in_accum  = 16'hFFFF;
        w_in_data   = 16'h0001;
        @(negedge clk);
        check("w16_in_ready", 64'(w_in_ready), 64'd1);
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (w_out_valid) break;
        end
        check("w16_out_valid", 64'(w_out_valid), 64'd1);
        check("w16_result", 64'(w_out_result), 64'(EXP_ADD16));
        check("w16_flags", {w_out_zero, w_out_carry}, {EXP_ZERO16, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
